// File: rtl/rr_arb_enc_4_2_pkg.sv
// Shared arbiter definitions: widths, FSM states, requester indices and
// the request-vector rotation helper used ahead of the priority encoder.
package rr_arb_enc_4_2_pkg;

    localparam int unsigned ARB_N     = 4;
    localparam int unsigned ARB_IDX_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic [ARB_IDX_W-1:0] ARB_ICACHE  = 2'd0;
    localparam logic [ARB_IDX_W-1:0] ARB_DCACHE  = 2'd1;
    localparam logic [ARB_IDX_W-1:0] ARB_UNCACHE = 2'd2;
    localparam logic [ARB_IDX_W-1:0] ARB_WBUF    = 2'd3;

    // Bit i of the result is request (i + sh) mod 4, so index 0 holds the pointer.
    function automatic logic [ARB_N-1:0] rot_right(input logic [ARB_N-1:0]     v,
                                                    input logic [ARB_IDX_W-1:0] sh);
        logic [ARB_N-1:0]     r;
        logic [ARB_IDX_W-1:0] j;
        r = '0;
        for (int unsigned i = 0; i < ARB_N; i++) begin
            j    = ARB_IDX_W'(i) + sh;
            r[i] = v[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_enc_4_2_prio_enc_4_2.sv
// Combinational 4->2 priority encoder: index of the lowest set bit plus an
// any-bit-set flag.
module prio_enc_4_2
    import rr_arb_enc_4_2_pkg::*;
(
    input  logic [ARB_N-1:0]     in,
    output logic [ARB_IDX_W-1:0] out,
    output logic                 any
);

    always_comb begin
        out = '0;
        any = |in;
        casez (in)
            4'b???1: out = 2'd0;
            4'b??10: out = 2'd1;
            4'b?100: out = 2'd2;
            4'b1000: out = 2'd3;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb_enc_4_2.sv
// 4-way bus-master arbiter with locked grants, round-robin or fixed priority,
// and a sticky error when the owner withdraws its request before done.
module rr_arb_enc_4_2
    import rr_arb_enc_4_2_pkg::*;
#(
    parameter bit                   RR_EN    = 1'b1,
    parameter logic [ARB_IDX_W-1:0] INIT_PTR = 2'd0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic                 grant_valid,
    output logic [ARB_IDX_W-1:0] grant_idx,
    output logic [ARB_N-1:0]     grant_oh,
    output logic                 busy_err
);

    arb_state_t           state, state_nxt;
    logic [ARB_IDX_W-1:0] ptr, ptr_nxt;
    logic [ARB_IDX_W-1:0] idx_nxt;
    logic                 err_nxt;
    logic [ARB_IDX_W-1:0] sel_ptr;
    logic                 rearb;
    logic [ARB_N-1:0]     req_rot;
    logic [ARB_IDX_W-1:0] enc_idx;
    logic                 enc_any;
    logic [ARB_IDX_W-1:0] winner;

    prio_enc_4_2 u_enc (
        .in  (req_rot),
        .out (enc_idx),
        .any (enc_any)
    );

    // On done the scan already uses the advanced pointer, so the outgoing
    // owner is lowest priority in the same-cycle re-arbitration.
    always_comb begin
        sel_ptr   = ptr;
        rearb     = 1'b0;
        state_nxt = state;
        idx_nxt   = grant_idx;
        ptr_nxt   = ptr;
        err_nxt   = busy_err;

        case (state)
            ARB_IDLE: rearb = 1'b1;
            ARB_GRANT: begin
                if (done) begin
                    rearb = 1'b1;
                    if (RR_EN) begin
                        sel_ptr = grant_idx + 2'd1;
                        ptr_nxt = grant_idx + 2'd1;
                    end
                end else if (!req[grant_idx]) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase

        if (!RR_EN) sel_ptr = '0;

        req_rot = rot_right(req, sel_ptr);
        winner  = enc_idx + sel_ptr;

        if (rearb) begin
            if (enc_any) begin
                state_nxt = ARB_GRANT;
                idx_nxt   = winner;
            end else begin
                state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            ptr       <= INIT_PTR;
            busy_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_idx <= idx_nxt;
            ptr       <= ptr_nxt;
            busy_err  <= err_nxt;
        end
    end

    assign grant_valid = (state == ARB_GRANT);
    assign grant_oh    = grant_valid ? (4'b0001 << grant_idx) : '0;

endmodule

// File: tb/tb_rr_arb_enc_4_2.sv
// Bench for rr_arb_enc_4_2: one round-robin and one fixed-priority instance
// driven together and compared every cycle against an owner/pointer model.
module tb_rr_arb_enc_4_2;
    import rr_arb_enc_4_2_pkg::*;

    localparam logic [1:0] FX_INIT = 2'd2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    logic       gv_r, err_r, gv_f, err_f;
    logic [1:0] gi_r, gi_f;
    logic [3:0] oh_r, oh_f;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner[2];
    int m_ptr[2];
    int m_last[2];
    bit m_err[2];

    always #5 clk = ~clk;

    rr_arb_enc_4_2 #(.RR_EN(1'b1), .INIT_PTR(2'd0)) dut_rr (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .grant_valid(gv_r), .grant_idx(gi_r), .grant_oh(oh_r), .busy_err(err_r)
    );

    rr_arb_enc_4_2 #(.RR_EN(1'b0), .INIT_PTR(FX_INIT)) dut_fx (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .grant_valid(gv_f), .grant_idx(gi_f), .grant_oh(oh_f), .busy_err(err_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int o);
        return (o < 0) ? 32'd0 : (32'd1 << o);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = (m == 0) ? 0 : int'(FX_INIT);
            m_last[m]  = 0;
            m_err[m]   = 1'b0;
        end
    endtask

    task automatic model_step(input int m);
        bit rr;
        int w;
        rr = (m == 0);
        if (m_owner[m] < 0) begin
            if (req != 4'b0000) begin
                w = pick(req, rr ? m_ptr[m] : 0);
                m_owner[m] = w;
                m_last[m]  = w;
            end
        end else if (done) begin
            if (rr) m_ptr[m] = (m_owner[m] + 1) % 4;
            w = pick(req, rr ? m_ptr[m] : 0);
            m_owner[m] = w;
            if (w >= 0) m_last[m] = w;
        end else if (!req[m_owner[m]]) begin
            m_err[m] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_all();
        chk("rr_valid", gv_r,  m_owner[0] >= 0);
        chk("rr_idx",   gi_r,  m_last[0]);
        chk("rr_oh",    oh_r,  onehot(m_owner[0]));
        chk("rr_err",   err_r, m_err[0]);
        chk("fx_valid", gv_f,  m_owner[1] >= 0);
        chk("fx_idx",   gi_f,  m_last[1]);
        chk("fx_oh",    oh_f,  onehot(m_owner[1]));
        chk("fx_err",   err_f, m_err[1]);
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asserts reset between edges and checks outputs before any clock arrives.
    task automatic async_reset();
        #2 resetn = 1'b0;
        #1 check_all();
        chk("rst_oh_r", oh_r, 0);
        chk("rst_gv_r", gv_r, 0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [1:0] seq [4];

    initial begin
        model_reset();
        seq[0] = ARB_ICACHE;
        seq[1] = ARB_DCACHE;
        seq[2] = ARB_UNCACHE;
        seq[3] = ARB_WBUF;

        req = 4'b1111;
        @(negedge clk);
        check_all();
        chk("rst_err_r", err_r, 0);
        resetn = 1'b1;

        step(4'b1111, 1'b0);
        chk("first_grant", gi_r, 0);
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
            chk("rot_seq", gi_r, seq[k % 4]);
            chk("rot_nogap", gv_r, 1);
        end

        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 1'b1);
            chk("fixed_hold", gi_f, ARB_DCACHE);
        end
        step(4'b1000, 1'b1);
        chk("fixed_drop", gi_f, ARB_WBUF);

        async_reset();
        step(4'b0001 << ARB_UNCACHE, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        chk("lock_idx", gi_r, 2);
        chk("lock_valid", gv_r, 1);
        chk("lock_err", err_r, 1);
        step(4'b0000, 1'b0);
        chk("err_sticky", err_r, 1);
        step(4'b0000, 1'b1);
        chk("to_idle", gv_r, 0);
        step(4'b0000, 1'b1);
        chk("done_idle", gv_r, 0);
        chk("done_idle_idx", gi_r, 2);

        async_reset();
        step(4'b0100, 1'b0);
        step(4'b0101, 1'b1);
        chk("wrap0", gi_r, 0);
        step(4'b0101, 1'b1);
        chk("wrap2", gi_r, 2);

        step(4'b1111, 1'b1);
        async_reset();
        step(4'b1111, 1'b0);
        chk("ptr_reinit", gi_r, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) async_reset();
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
